// File: rtl/dmem_ctrl.sv
// Data-memory access controller sitting behind the MEM stage.
// Turns level MEM-stage load/store requests into a req/ack handshake with a
// variable-latency word RAM, stalls the pipeline until the access finishes,
// and flags misaligned addresses and RAM timeouts with one-cycle pulses.
module dmem_ctrl #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        ram_req,
  output logic        ram_we,
  output logic [29:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  output logic        align_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Last counter value before the access is abandoned.
  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  state_e      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_mem_din, w_mem_din_nxt;
  logic        r_ram_req, w_ram_req_nxt;
  logic        r_ram_we, w_ram_we_nxt;
  logic [29:0] r_ram_addr, w_ram_addr_nxt;
  logic [31:0] r_ram_wdata, w_ram_wdata_nxt;
  logic        r_align_err, w_align_err_nxt;
  logic        r_bus_err, w_bus_err_nxt;

  logic w_req;
  logic w_wr;
  logic w_misaligned;

  assign w_req        = mem_ren | mem_wen;
  // A simultaneous read and write request is treated as a write.
  assign w_wr         = mem_wen;
  assign w_misaligned = w_req & (mem_addr[1:0] != 2'b00);

  // Stall while an aligned request is outstanding; DONE releases the pipeline.
  assign mem_stall = w_req & (r_state != StDone) & ~w_misaligned;

  assign mem_din   = r_mem_din;
  assign ram_req   = r_ram_req;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign align_err = r_align_err;
  assign bus_err   = r_bus_err;

  // State and output registers; reset drops ram_req immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= 8'd0;
      r_mem_din   <= 32'd0;
      r_ram_req   <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= 30'd0;
      r_ram_wdata <= 32'd0;
      r_align_err <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_din   <= w_mem_din_nxt;
      r_ram_req   <= w_ram_req_nxt;
      r_ram_we    <= w_ram_we_nxt;
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_wdata <= w_ram_wdata_nxt;
      r_align_err <= w_align_err_nxt;
      r_bus_err   <= w_bus_err_nxt;
    end
  end

  // Next-state and next-output logic; everything holds unless updated below.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_mem_din_nxt   = r_mem_din;
    w_ram_req_nxt   = r_ram_req;
    w_ram_we_nxt    = r_ram_we;
    w_ram_addr_nxt  = r_ram_addr;
    w_ram_wdata_nxt = r_ram_wdata;
    w_align_err_nxt = 1'b0;
    w_bus_err_nxt   = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_misaligned) begin
          // No RAM access; the pipeline advances this cycle without a stall.
          w_align_err_nxt = 1'b1;
          if (!w_wr) w_mem_din_nxt = ERR_DATA;
          w_state_nxt = StDone;
        end else if (w_req) begin
          w_ram_req_nxt   = 1'b1;
          w_ram_we_nxt    = w_wr;
          w_ram_addr_nxt  = mem_addr[31:2];
          w_ram_wdata_nxt = mem_dout;
          w_cnt_nxt       = 8'd0;
          w_state_nxt     = StReq;
        end
      end

      StReq: begin
        if (ram_ack) begin
          w_ram_req_nxt = 1'b0;
          if (!r_ram_we) w_mem_din_nxt = ram_rdata;
          w_state_nxt = StDone;
        end else if (r_cnt == TmoLast) begin
          w_ram_req_nxt = 1'b0;
          w_bus_err_nxt = 1'b1;
          if (!r_ram_we) w_mem_din_nxt = ERR_DATA;
          w_state_nxt = StDone;
        end else if (r_cnt != 8'hFF) begin
          // Saturating; never wraps back to zero.
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end

      StDone: begin
        w_state_nxt = StIdle;
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: a transaction-level model computes the
// expected cycle-by-cycle outputs from the access latency rules, a compare
// process checks the DUT every cycle, and literal checks pin the model.
module tb_dmem_ctrl;

  localparam int unsigned TMO = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_dout;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        ram_req, ram_we;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        ram_ack;
  logic        align_err, bus_err;

  dmem_ctrl #(
    .TIMEOUT (TMO),
    .ERR_DATA(ERR)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .mem_ren  (mem_ren),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_dout (mem_dout),
    .mem_din  (mem_din),
    .mem_stall(mem_stall),
    .ram_req  (ram_req),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .ram_ack  (ram_ack),
    .align_err(align_err),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Expected outputs for the current cycle.
  bit          exp_on = 1'b0;
  logic [31:0] exp_din, exp_wdata;
  logic [29:0] exp_addr;
  logic        exp_we, exp_req, exp_stall, exp_align, exp_bus;

  // Observed activity within one transaction.
  int cnt_stall, cnt_req, cnt_align, cnt_bus;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_on) begin
      chk("mem_stall", 32'(mem_stall), 32'(exp_stall));
      chk("ram_req",   32'(ram_req),   32'(exp_req));
      chk("ram_we",    32'(ram_we),    32'(exp_we));
      chk("ram_addr",  32'(ram_addr),  32'(exp_addr));
      chk("ram_wdata", ram_wdata,      exp_wdata);
      chk("mem_din",   mem_din,        exp_din);
      chk("align_err", 32'(align_err), 32'(exp_align));
      chk("bus_err",   32'(bus_err),   32'(exp_bus));
    end
  end

  task automatic model_reset();
    exp_din = 32'd0; exp_wdata = 32'd0; exp_addr = 30'd0; exp_we = 1'b0;
    exp_req = 1'b0; exp_stall = 1'b0; exp_align = 1'b0; exp_bus = 1'b0;
  endtask

  task automatic cycle_begin();
    @(posedge clk);
    #1;
    ram_ack   = 1'b0;
    exp_align = 1'b0;
    exp_bus   = 1'b0;
    exp_stall = 1'b0;
    exp_req   = 1'b0;
  endtask

  task automatic cycle_end();
    @(negedge clk);
    #1;
    if (mem_stall) cnt_stall++;
    if (ram_req)   cnt_req++;
    if (align_err) cnt_align++;
    if (bus_err)   cnt_bus++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cycle_begin();
      mem_ren = 1'b0;
      mem_wen = 1'b0;
      cycle_end();
    end
  endtask

  // One MEM-stage access starting with the controller idle. ack_n is the REQ
  // cycle in which the RAM acks (1 = first); 0 or > TMO means no ack.
  task automatic access(input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [31:0] dout, input int ack_n, input logic [31:0] rdata);
    bit is_rd;
    bit tmo;
    int len;
    is_rd = ~wen;
    cnt_stall = 0; cnt_req = 0; cnt_align = 0; cnt_bus = 0;
    cycle_begin();
    mem_ren = ren; mem_wen = wen; mem_addr = addr; mem_dout = dout;
    if (addr[1:0] != 2'b00) begin
      exp_stall = 1'b0;
      cycle_end();
      cycle_begin();
      mem_ren = 1'b0; mem_wen = 1'b0;
      exp_align = 1'b1;
      if (is_rd) exp_din = ERR;
      cycle_end();
    end else begin
      tmo = (ack_n == 0) || (ack_n > int'(TMO));
      len = tmo ? int'(TMO) : ack_n;
      exp_stall = 1'b1;
      cycle_end();
      for (int k = 1; k <= len; k++) begin
        cycle_begin();
        ram_ack   = (!tmo && k == len);
        ram_rdata = (!tmo && k == len) ? rdata : (32'h0BAD_0000 + 32'(k));
        exp_stall = 1'b1;
        exp_req   = 1'b1;
        exp_we    = wen;
        exp_addr  = addr[31:2];
        exp_wdata = dout;
        cycle_end();
      end
      cycle_begin();
      exp_bus = tmo;
      if (is_rd) exp_din = tmo ? ERR : rdata;
      cycle_end();
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = 32'd0; mem_dout = 32'd0;
    ram_rdata = 32'd0; ram_ack = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_din", mem_din, 32'd0);
    chk("rst_ram_req", 32'(ram_req), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_on = 1'b1;
    idle(2);

    // Aligned load, ack in second REQ cycle.
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 2, 32'h1234_5678);
    chk("load_stall_cycles", 32'(cnt_stall), 32'd3);
    chk("load_din", mem_din, 32'h1234_5678);
    chk("load_ram_addr", 32'(ram_addr), 32'h4);
    chk("load_ram_we", 32'(ram_we), 32'd0);

    // Aligned store, ack in first REQ cycle.
    access(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_0001, 1, 32'h0);
    chk("store_stall_cycles", 32'(cnt_stall), 32'd2);
    chk("store_ram_we", 32'(ram_we), 32'd1);
    chk("store_ram_addr", 32'(ram_addr), 32'h8);
    chk("store_wdata", ram_wdata, 32'hCAFE_0001);
    chk("store_din_kept", mem_din, 32'h1234_5678);
    idle(1);

    // Misaligned load.
    access(1'b1, 1'b0, 32'h0000_0013, 32'h0, 1, 32'h0);
    chk("mis_req_cycles", 32'(cnt_req), 32'd0);
    chk("mis_align_pulses", 32'(cnt_align), 32'd1);
    chk("mis_stall_cycles", 32'(cnt_stall), 32'd0);
    chk("mis_din", mem_din, 32'hDEAD_BEEF);

    // Timeout on a load.
    access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 0, 32'h0);
    chk("tmo_req_cycles", 32'(cnt_req), 32'd4);
    chk("tmo_bus_pulses", 32'(cnt_bus), 32'd1);
    chk("tmo_din", mem_din, 32'hDEAD_BEEF);

    // Read and write together: treated as a write.
    access(1'b1, 1'b1, 32'h0000_0040, 32'h7777_0000, 3, 32'h1111_2222);
    chk("both_ram_we", 32'(ram_we), 32'd1);
    chk("both_din_kept", mem_din, 32'hDEAD_BEEF);

    // Back-to-back loads, minimum latency.
    access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 1, 32'hA5A5_0001);
    chk("b2b_stall_cycles", 32'(cnt_stall), 32'd2);
    access(1'b1, 1'b0, 32'h0000_0048, 32'h0, 1, 32'hA5A5_0002);
    chk("b2b_din", mem_din, 32'hA5A5_0002);

    // Misaligned store leaves mem_din alone.
    access(1'b0, 1'b1, 32'h0000_0022, 32'h1234_0000, 1, 32'h0);
    chk("mis_wr_din", mem_din, 32'hA5A5_0002);

    // Ack in the last cycle before the timeout wins over the abort.
    access(1'b1, 1'b0, 32'h0000_0050, 32'h0, int'(TMO), 32'h0F0F_F0F0);
    chk("edge_bus_pulses", 32'(cnt_bus), 32'd0);
    chk("edge_din", mem_din, 32'h0F0F_F0F0);
    idle(1);

    // Reset in the middle of a load, then a late ack.
    cycle_begin();
    mem_ren = 1'b1; mem_wen = 1'b0; mem_addr = 32'h0000_0080;
    exp_stall = 1'b1;
    cycle_end();
    cycle_begin();
    exp_stall = 1'b1; exp_req = 1'b1; exp_we = 1'b0; exp_addr = 30'h20; exp_wdata = mem_dout;
    cycle_end();
    #1;
    rst = 1'b1;
    mem_ren = 1'b0;
    model_reset();
    #1;
    chk("midrst_ram_req", 32'(ram_req), 32'd0);
    chk("midrst_ram_addr", 32'(ram_addr), 32'd0);
    chk("midrst_din", mem_din, 32'd0);
    cycle_begin();
    cycle_end();
    cycle_begin();
    rst = 1'b0;
    cycle_end();
    cycle_begin();
    ram_ack = 1'b1;
    ram_rdata = 32'h5555_AAAA;
    cycle_end();
    idle(2);
    chk("late_ack_din", mem_din, 32'd0);
    chk("late_ack_req", 32'(ram_req), 32'd0);

    exp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
